// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller.
// Covers opcodes, FSM states, ALUOp, datapath selects and ALU control codes.
package multicycle_pkg;

  localparam int unsigned STATE_BITS = 4;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_JAL      = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Per-state control word produced by the main FSM decode.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, selects/enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, illegal_instr
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction funct fields.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // sub only for R-type; addi with imm[10]=1 must stay add
          3'b000:  o_alu_control = (i_funct7b5 & i_op5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for the multicycle CPU; sequences datapath selects and enables.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus,
  output logic [STATE_W-1:0]     state_dbg
);

  logic [STATE_BITS-1:0] r_state;
  logic [STATE_BITS-1:0] w_cur;
  logic [STATE_BITS-1:0] w_next;
  ctrl_t                 w_ctrl;
  logic [2:0]            w_alu_control;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Decode FETCH while reset is held so an abandoned store/writeback never fires.
  assign w_cur = reset ? S_FETCH : r_state;

  always_comb begin
    w_next = S_FETCH;
    w_ctrl = '0;
    case (w_cur)
      S_FETCH: begin
        w_ctrl.ir_write   = 1'b1;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.aluop      = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURESULT;
        w_ctrl.pc_update  = 1'b1;
        w_next            = S_DECODE;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.aluop     = ALUOP_ADD;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTER;
          OP_ITYPE:     w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            w_ctrl.illegal = 1'b1;
            w_next         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.aluop     = ALUOP_ADD;
        w_next           = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.adr_src    = 1'b1;
        w_next            = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEMWRITE: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.mem_write  = 1'b1;
        w_next            = S_FETCH;
      end
      S_EXECUTER: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_RD2;
        w_ctrl.aluop     = ALUOP_FUNCT;
        w_next           = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.aluop     = ALUOP_FUNCT;
        w_next           = S_ALUWB;
      end
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.aluop      = ALUOP_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_update  = 1'b1;
        w_next            = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_next            = S_FETCH;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a  = SRCA_RD1;
        w_ctrl.alu_src_b  = SRCB_RD2;
        w_ctrl.aluop      = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.branch     = 1'b1;
        w_next            = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop       (w_ctrl.aluop),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_op5         (bus.op[5]),
    .o_alu_control (w_alu_control)
  );

  assign bus.pc_write      = w_ctrl.pc_update | (w_ctrl.branch & bus.zero);
  assign bus.adr_src       = w_ctrl.adr_src;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.result_src    = w_ctrl.result_src;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.imm_src       = imm_decode(bus.op);
  assign bus.alu_control   = w_alu_control;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.illegal_instr = w_ctrl.illegal;
  assign state_dbg         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle expected state/outputs queued per instruction, popped at negedge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_dbg;

  multicycle_controller_if bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [16:0] dut_outs;
  assign dut_outs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                     bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                     bus.alu_control, bus.reg_write, bus.illegal_instr};

  // Reference outputs for one state, written from the control table.
  function automatic logic [16:0] model(input logic [3:0] s, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw, ill, fn;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; fn = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    if (op == 7'b0100011)      imm = 2'b01;
    else if (op == 7'b1100011) imm = 2'b10;
    else if (op == 7'b1101111) imm = 2'b11;
    else                       imm = 2'b00;
    case (s)
      4'd0:  begin irw = 1; b = 2'b10; rs = 2'b10; pcw = 1; end
      4'd1:  begin a = 2'b01; b = 2'b01;
               ill = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                       op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011); end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin rs = 2'b00; adr = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin a = 2'b10; b = 2'b00; fn = 1; end
      4'd7:  begin a = 2'b10; b = 2'b01; fn = 1; end
      4'd8:  begin a = 2'b01; b = 2'b10; pcw = 1; end
      4'd9:  begin rw = 1; end
      4'd10: begin a = 2'b10; alu = 3'b001; pcw = z; end
      default: ;
    endcase
    if (fn) begin
      case (f3)
        3'b000:  alu = (f7 && op[5]) ? 3'b001 : 3'b000;
        3'b010:  alu = 3'b101;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, ill};
  endfunction

  task automatic check_now(input string tag, input exp_t e);
    n_tests++;
    assert (state_dbg === e.st) else begin
      n_fail++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, e.st);
    end
    n_tests++;
    assert (dut_outs === e.outs) else begin
      n_fail++;
      $error("FAIL %s outs(state %0d) observed=%b expected=%b", tag, e.st, dut_outs, e.outs);
    end
  endtask

  // Drive one instruction from FETCH; check up to max_cycles cycles, then drop the rest.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int max_cycles);
    logic [3:0] seq[$];
    exp_t e;
    int n;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    seq = {4'd0, 4'd1};
    case (op)
      7'b0000011: seq = {seq, 4'd2, 4'd3, 4'd4};
      7'b0100011: seq = {seq, 4'd2, 4'd5};
      7'b0110011: seq = {seq, 4'd6, 4'd9};
      7'b0010011: seq = {seq, 4'd7, 4'd9};
      7'b1101111: seq = {seq, 4'd8, 4'd9};
      7'b1100011: seq = {seq, 4'd10};
      default: ;
    endcase
    foreach (seq[i]) sb.push_back('{st: seq[i], outs: model(seq[i], op, f3, f7, z)});
    n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      e = sb.pop_front();
      check_now($sformatf("%s c%0d", tag, n), e);
      @(posedge clk); #1;
      n++;
    end
    sb.delete();
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    e = '{st: 4'd0, outs: model(4'd0, 7'b0, 3'b0, 1'b0, 1'b0)};
    check_now("reset", e);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("lw",        7'b0000011, 3'b010, 1'b0, 1'b0, 99);
    run_instr("sw",        7'b0100011, 3'b010, 1'b0, 1'b0, 99);
    run_instr("r_sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 99);
    run_instr("addi_f7",   7'b0010011, 3'b000, 1'b1, 1'b0, 99);
    run_instr("r_and",     7'b0110011, 3'b111, 1'b0, 1'b0, 99);
    run_instr("r_slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 99);
    run_instr("ori",       7'b0010011, 3'b110, 1'b0, 1'b0, 99);
    run_instr("r_add",     7'b0110011, 3'b000, 1'b0, 1'b1, 99);
    run_instr("i_f3other", 7'b0010011, 3'b100, 1'b0, 1'b0, 99);
    run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 99);
    run_instr("beq_not",   7'b1100011, 3'b000, 1'b0, 1'b0, 99);
    run_instr("jal",       7'b1101111, 3'b000, 1'b0, 1'b1, 99);
    run_instr("illegal",   7'b1111111, 3'b000, 1'b0, 1'b0, 99);

    // Abandon a store: reset asserted while in MEMWRITE.
    run_instr("sw_abort",  7'b0100011, 3'b010, 1'b0, 1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    e = '{st: 4'd5, outs: model(4'd0, 7'b0100011, 3'b010, 1'b0, 1'b0)};
    check_now("rst_in_memwrite", e);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("after_rst", 7'b1100011, 3'b000, 1'b0, 1'b1, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
